// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants, divider state encoding and field helper.
package fp_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] INF_MAG = 32'h7F800000;

    typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, ROUND, DONE} divState_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fpField_t;

    function automatic fpField_t fields(input logic [31:0] x);
        return fpField_t'(x);
    endfunction
endpackage

// File: rtl/xor_signo.sv
// xor_signo: sign of a product or quotient from the two operand signs.
module xor_signo (
    input  logic signA,
    input  logic signB,
    output logic signo
);
    assign signo = signA ^ signB;
endmodule

// File: rtl/divisor_fp.sv
// divisor_fp: sequential IEEE-754 single divider, restoring radix-2, round-to-nearest-even.
// Subnormal inputs read as signed zero; results below the normal range flush to signed zero.
module divisor_fp
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 ready,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 div_cero,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int QW = MAN_W + 3;
    localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'(EXP_MAX);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;

    divState_t state, nextState;
    logic [EXP_W+MAN_W:0] aReg, bReg, specRes, roundRes;
    fpField_t fa, fb;
    logic sgn, aNan, aInf, aZero, bNan, bInf, bZero, isNan, special, specDz;
    logic [MAN_W+1:0] rem, nextRem;
    logic [MAN_W:0] mb, fracSum;
    logic [MAN_W-1:0] frac;
    logic [QW-1:0] quo;
    logic [4:0] cnt;
    logic signed [EXP_W+1:0] expR, expAdj, expFin;
    logic geq, hi, guard, sticky, roundUp, ofl, ufl;

    assign fa = fields(aReg);
    assign fb = fields(bReg);

    xor_signo uSign (.signA(fa.sign), .signB(fb.sign), .signo(sgn));

    assign aNan = (&fa.exp) & (|fa.frac);
    assign aInf = (&fa.exp) & ~(|fa.frac);
    assign aZero = ~(|fa.exp);
    assign bNan = (&fb.exp) & (|fb.frac);
    assign bInf = (&fb.exp) & ~(|fb.frac);
    assign bZero = ~(|fb.exp);
    assign isNan = aNan | bNan | (aZero & bZero) | (aInf & bInf);
    assign special = isNan | aInf | aZero | bInf | bZero;
    assign specRes = isNan ? QNAN : (aInf | bZero) ? {sgn, INF_MAG[30:0]} : {sgn, 31'b0};
    assign specDz = ~isNan & bZero & ~aInf;

    // One restoring step: subtract the divisor when it fits, then shift for the next quotient bit
    assign mb = {1'b1, fb.frac};
    assign geq = rem >= {1'b0, mb};
    assign nextRem = geq ? rem - {1'b0, mb} : rem;

    // Quotient lies in (2^24, 2^26): the top bit decides which 24-bit window holds the mantissa
    assign hi = quo[QW-1];
    assign frac = hi ? quo[QW-2:2] : quo[QW-3:1];
    assign guard = hi ? quo[1] : quo[0];
    assign sticky = (hi & quo[0]) | (|rem);
    assign roundUp = guard & (sticky | frac[0]);
    assign fracSum = {1'b0, frac} + {{MAN_W{1'b0}}, roundUp};
    assign expAdj = hi ? expR : expR - (EXP_W+2)'(1);
    assign expFin = expAdj + {{(EXP_W+1){1'b0}}, fracSum[MAN_W]};
    assign ofl = expFin >= E_MAX;
    assign ufl = expFin <= E_ZERO;
    assign roundRes = ofl ? {sgn, INF_MAG[30:0]} : ufl ? {sgn, 31'b0} :
                      {sgn, expFin[EXP_W-1:0], fracSum[MAN_W-1:0]};

    always_comb begin
        nextState = state;
        ready = state == IDLE;
        done = state == DONE;
        case (state)
            IDLE:    nextState = start ? CHECK : IDLE;
            CHECK:   nextState = special ? DONE : DIVIDE;
            DIVIDE:  nextState = (cnt == 5'(QW-1)) ? ROUND : DIVIDE;
            ROUND:   nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            aReg <= '0;
            bReg <= '0;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            expR <= '0;
            result <= '0;
            div_cero <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (start) begin
                    aReg <= a;
                    bReg <= b;
                    div_cero <= 1'b0;
                    overflow <= 1'b0;
                    underflow <= 1'b0;
                end
                CHECK: begin
                    rem <= {2'b01, fa.frac};
                    quo <= '0;
                    cnt <= '0;
                    expR <= (EXP_W+2)'(fa.exp) - (EXP_W+2)'(fb.exp) + (EXP_W+2)'(EXP_BIAS);
                    if (special) begin
                        result <= specRes;
                        div_cero <= specDz;
                    end
                end
                DIVIDE: begin
                    rem <= nextRem << 1;
                    quo <= {quo[QW-2:0], geq};
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    result <= roundRes;
                    overflow <= ofl;
                    underflow <= ufl;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_fp.sv
// tb_divisor_fp: directed vectors for divisor_fp, checked against an arithmetic reference model.
module tb_divisor_fp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic ready, done, div_cero, overflow, underflow;
    logic [31:0] result;

    int total = 0, bad = 0, cyc = 0;

    divisor_fp dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .result(result),
        .div_cero(div_cero), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Reference: {special, result, div_cero, overflow, underflow} from plain integer division
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s, xn, yn, xi, yi, xz, yz, g, st;
        longint unsigned ma, mb, q, r, man;
        int e;
        s = x[31] ^ y[31];
        xn = x[30:23] == 8'hFF && x[22:0] != 0;
        yn = y[30:23] == 8'hFF && y[22:0] != 0;
        xi = x[30:23] == 8'hFF && x[22:0] == 0;
        yi = y[30:23] == 8'hFF && y[22:0] == 0;
        xz = x[30:23] == 0;
        yz = y[30:23] == 0;
        if (xn || yn || (xz && yz) || (xi && yi)) return {1'b1, 32'h7FC00000, 3'b000};
        if (yz && !xi) return {1'b1, s, 8'hFF, 23'b0, 3'b100};
        if (xi) return {1'b1, s, 8'hFF, 23'b0, 3'b000};
        if (xz || yi) return {1'b1, s, 31'b0, 3'b000};
        ma = 64'(x[22:0]) + (64'd1 << 23);
        mb = 64'(y[22:0]) + (64'd1 << 23);
        q = (ma << 25) / mb;
        r = (ma << 25) % mb;
        e = int'(x[30:23]) - int'(y[30:23]) + 127;
        if (q >= (64'd1 << 25)) begin
            man = q >> 2;
            g = q[1];
            st = q[0] || r != 0;
        end else begin
            man = q >> 1;
            g = q[0];
            st = r != 0;
            e--;
        end
        if (g && (st || man[0])) man++;
        if (man == (64'd1 << 24)) begin
            man = 64'd1 << 23;
            e++;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'b0, 3'b010};
        if (e <= 0) return {1'b0, s, 31'b0, 3'b001};
        return {1'b0, s, 8'(e), man[22:0], 3'b000};
    endfunction

    logic pending = 1'b0, hasHeld = 1'b0;
    logic [35:0] expV;
    logic [34:0] heldV, lastV;
    int c0 = 0, doneCnt = 0, lastLat = 0, lastDoneCyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
            hasHeld = 1'b1;
            heldV = '0;
            chk("rst_state", {ready, done, result, div_cero, overflow, underflow}, {1'b1, 1'b0, 35'b0});
        end else begin
            chk("ready", ready, !pending);
            if (done) begin
                if (!pending) chk("spurious_done", done, 1'b0);
                else begin
                    chk("result", result, expV[34:3]);
                    chk("flags", {div_cero, overflow, underflow}, expV[2:0]);
                    chk("latency", cyc - c0 + 1, expV[35] ? 2 : 29);
                    lastV = {result, div_cero, overflow, underflow};
                    lastLat = cyc - c0 + 1;
                    lastDoneCyc = cyc;
                    doneCnt++;
                    pending = 1'b0;
                    heldV = expV[34:0];
                    hasHeld = 1'b1;
                end
            end else if (ready && hasHeld)
                chk("held", {result, div_cero, overflow, underflow}, heldV);
            if (ready && start) begin
                pending = 1'b1;
                hasHeld = 1'b0;
                expV = model(a, b);
                c0 = cyc + 1;
            end
        end
    end

    task automatic waitReady();
        @(posedge clk);
        #1;
        for (int i = 0; i < 60 && !ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_ready", ready, 1'b1);
    endtask

    task automatic waitDone(input string nm, input int d, input int lim);
        for (int i = 0; i < lim && doneCnt < d; i++) begin
            @(negedge clk);
            #1;
        end
        chk({nm, "_timeout"}, doneCnt, d);
    endtask

    task automatic runVec(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] res, input logic [2:0] fl, input int lat);
        logic [35:0] m;
        int d;
        m = model(x, y);
        chk({nm, "_model"}, m[34:0], {res, fl});
        waitReady();
        d = doneCnt + 1;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(nm, d, 60);
        chk({nm, "_out"}, lastV, {res, fl});
        chk({nm, "_lat"}, lastLat, lat);
    endtask

    task automatic launchThenPulse();
        waitReady();
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    int d, t1;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        runVec("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29);
        runVec("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29);
        runVec("neg_one_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 3'b100, 2);
        runVec("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 2);
        runVec("overflow", 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 3'b010, 29);
        runVec("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 3'b001, 29);
        runVec("inf_by_two", 32'h7F800000, 32'h40000000, 32'h7F800000, 3'b000, 2);
        runVec("inf_by_inf", 32'hFF800000, 32'h7F800000, 32'h7FC00000, 3'b000, 2);
        runVec("two_by_neginf", 32'h40000000, 32'hFF800000, 32'h80000000, 3'b000, 2);
        runVec("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 2);
        runVec("subnormal_in", 32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 2);
        runVec("negzero_by_neg3", 32'h80000000, 32'hC0400000, 32'h00000000, 3'b000, 2);
        runVec("neg6_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 29);
        runVec("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 29);

        d = doneCnt + 1;
        launchThenPulse();
        waitDone("busy_start", d, 60);
        chk("busy_start_out", lastV, {32'h40400000, 3'b000});
        repeat (40) @(posedge clk);
        #1 chk("busy_start_single", doneCnt, d);

        d = doneCnt;
        launchThenPulse();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_mid_ready", ready, 1'b1);
        chk("rst_mid_result", result, 32'h0);
        chk("rst_mid_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (35) @(posedge clk);
        #1 chk("rst_no_done", doneCnt, d);
        runVec("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29);

        waitReady();
        d = doneCnt;
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        waitDone("b2b_first", d + 1, 60);
        t1 = lastDoneCyc;
        waitDone("b2b_second", d + 2, 60);
        start = 1'b0;
        chk("b2b_gap", lastDoneCyc - t1, 30);
        chk("b2b_out", lastV, {32'h3EAAAAAB, 3'b000});
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/divisor_fp.md
# divisor_fp

Sequential IEEE-754 single-precision divider for the floating-point arithmetic datapath. It is the division counterpart of the multiplier. It computes a/b with a restoring radix-2 mantissa divider, rounds to nearest-even, and reports exceptions. The result sign comes from the existing `xor_signo` gate. A start/ready/done handshake lets a controller launch one division at a time.

## Interface
Parameters:
- `EXP_W`, default 8: exponent width. Only the default is supported and verified.
- `MAN_W`, default 23: stored fraction width. Only the default is supported and verified.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: launch request. Sampled only while `ready`=1.
- `a`, input, 32: dividend, IEEE-754 single. Captured on accepted start.
- `b`, input, 32: divisor, IEEE-754 single. Captured on accepted start.
- `ready`, output, 1: high only in IDLE.
- `done`, output, 1: one-cycle pulse when `result` becomes valid.
- `result`, output, 32: quotient. Held from `done` until the next accepted start.
- `div_cero`, output, 1: finite nonzero / zero. Valid with `done`, held with `result`.
- `overflow`, output, 1: result exponent ≥ 255 before special handling. Valid with `done`, held with `result`.
- `underflow`, output, 1: result flushed to zero. Valid with `done`, held with `result`.

## Operation
- States: IDLE → CHECK → DIVIDE → ROUND → DONE → IDLE. CHECK goes directly to DONE for special cases.
- IDLE: on `start`=1, register `a` and `b` and go to CHECK.
- CHECK, input classification: subnormal inputs (exp=0, frac≠0) are treated as signed zero.
- CHECK, special-case priority:
  1. Any NaN, 0/0, or inf/inf gives `0x7FC00000`.
  2. Finite nonzero/0 gives signed inf and sets `div_cero`.
  3. inf/finite gives signed inf.
  4. 0/finite or finite/inf gives signed zero.
- Sign: `a[31]^b[31]` via `xor_signo`. Applies to every non-NaN result.
- Normal path:
  - ma = {1,a frac}, mb = {1,b frac}, both 24 bits.
  - Exponent: e = ea − eb + 127, 10-bit signed.
  - DIVIDE runs 26 iterations, producing q = floor(ma·2^25/mb) one bit per cycle, MSB first, plus remainder r.
- ROUND:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (r≠0).
  - Else: mantissa = q[24:1], guard = q[0], sticky = (r≠0), and e = e − 1.
  - Round up if guard & (sticky | mantissa LSB).
  - Mantissa carry-out gives mantissa 1.0 and e + 1.
- Exponent limits, applied after rounding:
  - e ≥ 255 gives signed inf and `overflow`=1.
  - e ≤ 0 gives signed zero and `underflow`=1. No subnormal outputs.
- Flags are cleared on each accepted start.

## Timing
- Reset state: IDLE, `ready`=1, `done`=0, `result`=0, all flags 0.
- Start is accepted at edge E0. CHECK occupies cycle 1.
- Special case: DONE in cycle 2, so latency is 2 cycles.
- Normal case: DIVIDE occupies cycles 2–27, ROUND cycle 28, DONE cycle 29. Latency is 29 cycles.
- `done` is high exactly during the DONE cycle. `ready` returns to 1 the following cycle.
- `start` while `ready`=0 is ignored. It never corrupts the operands being processed.
- `start` held high in IDLE right after DONE launches a new division. This is a back-to-back launch, one idle cycle between jobs.
- `rst` in any state: immediate return to reset values. The in-flight division is lost and no `done` pulse is produced.

## Structure
- Shared package/include `fp_pkg` holds:
  - Constants: `EXP_BIAS`=127, `EXP_MAX`=255, `QNAN`=`0x7FC00000`, `INF_MAG`=`0x7F800000`.
  - State encoding constants.
  - Field-slice helpers for sign/exponent/fraction.
- Sub-module: one instance of `xor_signo` for the sign.
- The 26-step restoring divider stays inline. It is one shift/subtract register set, so it gets no separate module.

## Test plan
- 6.0/2.0 (`0x40C00000`/`0x40000000`): `0x40400000`, `done` at cycle 29, all flags 0.
- 1.0/3.0 (`0x3F800000`/`0x40400000`): `0x3EAAAAAB`, checks round-up on guard plus sticky.
- −1.0/0 (`0xBF800000`/`0x00000000`): `0xFF800000`, `div_cero`=1, `done` at cycle 2. Also 0/0: `0x7FC00000`, `div_cero`=0.
- Overflow: `0x7F7FFFFF`/`0x3E800000` gives `0x7F800000` with `overflow`=1.
- Underflow: `0x00800000`/`0x40000000` gives `0x00000000` with `underflow`=1.
- Launch 6.0/2.0, pulse `start` with other operands at cycle 10, assert `rst` at cycle 15:
  - The cycle-10 start is ignored.
  - After `rst`: `ready`=1, `result`=0, no `done`.
  - A fresh launch then completes correctly.
